// File: rtl/jtkunio_colmix_pkg.sv
// Shared constants for the Kunio colour mixer.
// Holds the per-layer palette base bits, the backdrop index, the width of
// the transparency field, the layer-select enum and a small opacity helper.
package jtkunio_colmix_pkg;

    localparam logic [1:0] CHAR_BASE = 2'b00;
    localparam logic [1:0] SCR_BASE  = 2'b01;
    localparam logic       OBJ_BASE  = 1'b1;
    localparam logic [7:0] BACKDROP  = 8'h00;
    localparam int         TRANSP_W  = 3;

    typedef enum logic [1:0] {
        LYR_BACK,
        LYR_CHAR,
        LYR_SCR,
        LYR_OBJ
    } layer_e;

    // A layer pixel is transparent when its colour field is all zeros
    function automatic logic opaque(input logic [TRANSP_W-1:0] colour);
        return colour != '0;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM, read-first on both ports.
// Ports: clk0/data0/addr0/we0/q0 (port 0), clk1/data1/addr1/we1/q1 (port 1).
// Both ports share one write process, so clk0 and clk1 must come from the
// same clock; port 0 wins if both ports write the same address together.
module jtframe_dual_ram #(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          clk0,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    output logic [dw-1:0] q0,
    input  logic          clk1,
    input  logic [dw-1:0] data1,
    input  logic [aw-1:0] addr1,
    input  logic          we1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem [0:(2**aw)-1];

    always_ff @(posedge clk0) begin
        q0 <= mem[addr0];
        if (we1) mem[addr1] <= data1;
        if (we0) mem[addr0] <= data0;
    end

    always_ff @(posedge clk1) begin
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtkunio_colmix_prio.sv
// Fixed-priority layer select for the Kunio colour mixer (combinational).
// Ports: i_char_pxl/i_scr_pxl/i_obj_pxl layer pixels, i_gfx_en debug layer
// enables ([0] char, [1] scroll, [2] obj), o_idx 8-bit palette index.
// Priority: opaque char, then opaque obj, then scroll, then backdrop.
module jtkunio_colmix_prio
    import jtkunio_colmix_pkg::*;
(
    input  logic [5:0] i_char_pxl,
    input  logic [5:0] i_scr_pxl,
    input  logic [6:0] i_obj_pxl,
    input  logic [2:0] i_gfx_en,
    output logic [7:0] o_idx
);

    layer_e w_sel;

    always_comb begin
        w_sel = LYR_BACK;
        if (i_gfx_en[0] && opaque(i_char_pxl[TRANSP_W-1:0]))
            w_sel = LYR_CHAR;
        else if (i_gfx_en[2] && opaque(i_obj_pxl[TRANSP_W-1:0]))
            w_sel = LYR_OBJ;
        else if (i_gfx_en[1])
            w_sel = LYR_SCR;
    end

    always_comb begin
        o_idx = BACKDROP;
        case (w_sel)
            LYR_CHAR: o_idx = {CHAR_BASE, i_char_pxl};
            LYR_OBJ:  o_idx = {OBJ_BASE,  i_obj_pxl};
            LYR_SCR:  o_idx = {SCR_BASE,  i_scr_pxl};
            default:  o_idx = BACKDROP;
        endcase
    end

endmodule

// File: rtl/jtkunio_colmix.sv
// Kunio colour mixer: layer priority -> palette lookup -> blanked RGB444.
// Ports: clk/rst (sync, active high), pxl_cen pixel enable; CPU palette port
// cpu_addr (bit 8: 0 = {G,R} byte, 1 = {0,B} byte), pal_cs, cpu_wrn,
// cpu_dout, cpu_din (one clk latency); layer pixels char_pxl/scr_pxl/obj_pxl,
// gfx_en layer enables; LHBL/LVBL blanking in; red/green/blue and
// LHBL_dly/LVBL_dly out, all three pixel ticks behind their inputs.
module jtkunio_colmix
    import jtkunio_colmix_pkg::*;
#(
    parameter int BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic [8:0] cpu_addr,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    input  logic [5:0] char_pxl,
    input  logic [5:0] scr_pxl,
    input  logic [6:0] obj_pxl,
    input  logic [2:0] gfx_en,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0]           w_idx;
    logic [7:0]           r_idx;
    logic [7:0]           w_lo_q0, w_hi_q0, w_lo_q1, w_hi_q1;
    logic                 w_wr, w_wr_lo, w_wr_hi;
    logic                 r_cpu_hi;
    logic [BLANK_DLY-1:0] r_hbl_sr, r_vbl_sr;
    logic                 w_show;
    logic [3:0]           r_red, r_green, r_blue;
    logic                 r_lhbl_dly, r_lvbl_dly;
    logic [3:0]           w_unused_hi;

    jtkunio_colmix_prio u_prio (
        .i_char_pxl (char_pxl),
        .i_scr_pxl  (scr_pxl),
        .i_obj_pxl  (obj_pxl),
        .i_gfx_en   (gfx_en),
        .o_idx      (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst)          r_idx <= '0;
        else if (pxl_cen) r_idx <= w_idx;
    end

    // CPU port runs every clk; video port reads r_idx every clk so its data
    // is settled by the following pixel enable.
    assign w_wr    = pal_cs & ~cpu_wrn;
    assign w_wr_lo = w_wr & ~cpu_addr[8];
    assign w_wr_hi = w_wr &  cpu_addr[8];

    jtframe_dual_ram #(.dw(8), .aw(8)) u_pal_lo (
        .clk0  (clk),
        .data0 (cpu_dout),
        .addr0 (cpu_addr[7:0]),
        .we0   (w_wr_lo),
        .q0    (w_lo_q0),
        .clk1  (clk),
        .data1 ('0),
        .addr1 (r_idx),
        .we1   (1'b0),
        .q1    (w_lo_q1)
    );

    // Only the blue nibble is stored, so hi-half reads come back as {0,B}
    jtframe_dual_ram #(.dw(8), .aw(8)) u_pal_hi (
        .clk0  (clk),
        .data0 ({4'h0, cpu_dout[3:0]}),
        .addr0 (cpu_addr[7:0]),
        .we0   (w_wr_hi),
        .q0    (w_hi_q0),
        .clk1  (clk),
        .data1 ('0),
        .addr1 (r_idx),
        .we1   (1'b0),
        .q1    (w_hi_q1)
    );

    assign w_unused_hi = w_hi_q1[7:4];

    always_ff @(posedge clk) begin
        r_cpu_hi <= cpu_addr[8];
    end

    assign cpu_din = r_cpu_hi ? w_hi_q0 : w_lo_q0;

    // Blanking delay line; its tail lines up with the pixel whose palette
    // data is being latched, and is registered together with the RGB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hbl_sr <= '0;
            r_vbl_sr <= '0;
        end else if (pxl_cen) begin
            r_hbl_sr[0] <= LHBL;
            r_vbl_sr[0] <= LVBL;
            for (int unsigned i = 1; i < BLANK_DLY; i++) begin
                r_hbl_sr[i] <= r_hbl_sr[i-1];
                r_vbl_sr[i] <= r_vbl_sr[i-1];
            end
        end
    end

    assign w_show = r_hbl_sr[BLANK_DLY-1] & r_vbl_sr[BLANK_DLY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
            r_lhbl_dly <= 1'b0;
            r_lvbl_dly <= 1'b0;
        end else if (pxl_cen) begin
            r_red      <= w_show ? w_lo_q1[3:0] : '0;
            r_green    <= w_show ? w_lo_q1[7:4] : '0;
            r_blue     <= w_show ? w_hi_q1[3:0] : '0;
            r_lhbl_dly <= r_hbl_sr[BLANK_DLY-1];
            r_lvbl_dly <= r_vbl_sr[BLANK_DLY-1];
        end
    end

    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign LHBL_dly = r_lhbl_dly;
    assign LVBL_dly = r_lvbl_dly;

endmodule

// File: tb/tb_jtkunio_colmix.sv
module tb_jtkunio_colmix;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic [8:0] cpu_addr;
    logic       pal_cs;
    logic       cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] cpu_din;
    logic [5:0] char_pxl;
    logic [5:0] scr_pxl;
    logic [6:0] obj_pxl;
    logic [2:0] gfx_en;
    logic       LHBL, LVBL;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jtkunio_colmix #(.BLANK_DLY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .cpu_addr (cpu_addr),
        .pal_cs   (pal_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .char_pxl (char_pxl),
        .scr_pxl  (scr_pxl),
        .obj_pxl  (obj_pxl),
        .gfx_en   (gfx_en),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        pal_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        tick();
        pal_cs   = 1'b0;
        cpu_wrn  = 1'b1;
    endtask

    task automatic set_pxl(input logic [5:0] c, input logic [6:0] o, input logic [5:0] s);
        char_pxl = c;
        obj_pxl  = o;
        scr_pxl  = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
        end
        n_checks++;
        if ({LHBL_dly, LVBL_dly} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_blank: got %b expected 00", {LHBL_dly, LVBL_dly});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cpu_write(9'h045, 8'hA3);
        cpu_write(9'h145, 8'h07);
        cpu_write(9'h146, 8'hFB);
        set_pxl(6'h00, 7'h00, 6'h05);
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'h3A7) begin
            n_fail++;
            $display("FAIL basic_rgb: got %h expected 3a7", {red, green, blue});
        end
        n_checks++;
        if ({LHBL_dly, LVBL_dly} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_blank: got %b expected 11", {LHBL_dly, LVBL_dly});
        end
        cpu_addr = 9'h045;
        tick();
        n_checks++;
        if (cpu_din !== 8'hA3) begin
            n_fail++;
            $display("FAIL read_lo: got %h expected a3", cpu_din);
        end
        cpu_addr = 9'h145;
        tick();
        n_checks++;
        if (cpu_din !== 8'h07) begin
            n_fail++;
            $display("FAIL read_hi: got %h expected 07", cpu_din);
        end
        cpu_addr = 9'h146;
        tick();
        n_checks++;
        if (cpu_din !== 8'h0B) begin
            n_fail++;
            $display("FAIL read_hi_mask: got %h expected 0b", cpu_din);
        end
    endtask

    task automatic test_priority();
        cpu_write(9'h009, 8'h21);
        cpu_write(9'h109, 8'h0F);
        cpu_write(9'h091, 8'h54);
        cpu_write(9'h191, 8'h06);
        gfx_en = 3'b111;
        set_pxl(6'h09, 7'h11, 6'h05);
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'h12F) begin
            n_fail++;
            $display("FAIL prio_char: got %h expected 12f", {red, green, blue});
        end
        gfx_en = 3'b110;
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'h456) begin
            n_fail++;
            $display("FAIL prio_obj: got %h expected 456", {red, green, blue});
        end
        gfx_en = 3'b111;
    endtask

    task automatic test_transparent();
        cpu_write(9'h07F, 8'hC8);
        cpu_write(9'h17F, 8'h0D);
        cpu_write(9'h000, 8'h9E);
        cpu_write(9'h100, 8'h01);
        gfx_en = 3'b111;
        set_pxl(6'h08, 7'h10, 6'h3F);
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'h8CD) begin
            n_fail++;
            $display("FAIL transp_scroll: got %h expected 8cd", {red, green, blue});
        end
        gfx_en = 3'b101;
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'hE91) begin
            n_fail++;
            $display("FAIL transp_backdrop: got %h expected e91", {red, green, blue});
        end
        gfx_en = 3'b000;
        set_pxl(6'h09, 7'h11, 6'h05);
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'hE91) begin
            n_fail++;
            $display("FAIL all_layers_off: got %h expected e91", {red, green, blue});
        end
        gfx_en = 3'b111;
    endtask

    task automatic test_blank();
        logic       exp_l;
        logic [11:0] exp_rgb;
        set_pxl(6'h00, 7'h00, 6'h05);
        tick(3);
        // LHBL low on ticks 1..4; each output tick k reflects input tick k-2
        for (int k = 0; k < 9; k++) begin
            LHBL = (k >= 1 && k <= 4) ? 1'b0 : 1'b1;
            tick();
            exp_l   = (k - 2 >= 1 && k - 2 <= 4) ? 1'b0 : 1'b1;
            exp_rgb = exp_l ? 12'h3A7 : 12'h000;
            n_checks++;
            if (LHBL_dly !== exp_l) begin
                n_fail++;
                $display("FAIL hblank_dly[%0d]: got %b expected %b", k, LHBL_dly, exp_l);
            end
            n_checks++;
            if ({red, green, blue} !== exp_rgb) begin
                n_fail++;
                $display("FAIL hblank_rgb[%0d]: got %h expected %h", k, {red, green, blue}, exp_rgb);
            end
        end
        LHBL = 1'b1;
        tick(3);
        LVBL = 1'b0;
        tick();
        LVBL = 1'b1;
        tick();
        n_checks++;
        if (LVBL_dly !== 1'b1) begin
            n_fail++;
            $display("FAIL vblank_early: got %b expected 1", LVBL_dly);
        end
        tick();
        n_checks++;
        if ({LVBL_dly, red, green, blue} !== 13'h0000) begin
            n_fail++;
            $display("FAIL vblank_low: got %h expected 0000", {LVBL_dly, red, green, blue});
        end
        tick();
        n_checks++;
        if ({LVBL_dly, red, green, blue} !== {1'b1, 12'h3A7}) begin
            n_fail++;
            $display("FAIL vblank_end: got %h expected 13a7", {LVBL_dly, red, green, blue});
        end
    endtask

    task automatic test_collision();
        cpu_write(9'h012, 8'h11);
        cpu_write(9'h112, 8'h01);
        set_pxl(6'h09, 7'h00, 6'h05);
        tick(3);
        set_pxl(6'h12, 7'h00, 6'h05);
        tick();
        cpu_addr = 9'h012;
        cpu_dout = 8'h77;
        pal_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        tick();
        pal_cs   = 1'b0;
        cpu_wrn  = 1'b1;
        n_checks++;
        if ({red, green, blue} !== 12'h12F) begin
            n_fail++;
            $display("FAIL coll_prev: got %h expected 12f", {red, green, blue});
        end
        tick();
        n_checks++;
        if ({red, green, blue} !== 12'h111) begin
            n_fail++;
            $display("FAIL coll_old: got %h expected 111", {red, green, blue});
        end
        tick();
        n_checks++;
        if ({red, green, blue} !== 12'h771) begin
            n_fail++;
            $display("FAIL coll_new: got %h expected 771", {red, green, blue});
        end
    endtask

    task automatic test_cen_hold();
        pxl_cen = 1'b0;
        set_pxl(6'h09, 7'h00, 6'h05);
        LHBL = 1'b0;
        cpu_write(9'h020, 8'h5A);
        tick(3);
        n_checks++;
        if ({LHBL_dly, red, green, blue} !== {1'b1, 12'h771}) begin
            n_fail++;
            $display("FAIL cen_hold: got %h expected 1771", {LHBL_dly, red, green, blue});
        end
        cpu_addr = 9'h020;
        tick();
        n_checks++;
        if (cpu_din !== 8'h5A) begin
            n_fail++;
            $display("FAIL cen_cpu_write: got %h expected 5a", cpu_din);
        end
        LHBL    = 1'b1;
        pxl_cen = 1'b1;
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'h12F) begin
            n_fail++;
            $display("FAIL cen_resume: got %h expected 12f", {red, green, blue});
        end
    endtask

    task automatic test_reset_midline();
        set_pxl(6'h00, 7'h00, 6'h05);
        tick(3);
        n_checks++;
        if ({red, green, blue} !== 12'h3A7) begin
            n_fail++;
            $display("FAIL rst_pre: got %h expected 3a7", {red, green, blue});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({LHBL_dly, LVBL_dly, red, green, blue} !== 14'h0000) begin
            n_fail++;
            $display("FAIL rst_flush: got %h expected 0000", {LHBL_dly, LVBL_dly, red, green, blue});
        end
        tick(2);
        n_checks++;
        if ({LHBL_dly, red, green, blue} !== 13'h0000) begin
            n_fail++;
            $display("FAIL rst_still_blank: got %h expected 0000", {LHBL_dly, red, green, blue});
        end
        tick();
        n_checks++;
        if ({LHBL_dly, red, green, blue} !== {1'b1, 12'h3A7}) begin
            n_fail++;
            $display("FAIL rst_recover: got %h expected 13a7", {LHBL_dly, red, green, blue});
        end
        cpu_addr = 9'h045;
        tick();
        n_checks++;
        if (cpu_din !== 8'hA3) begin
            n_fail++;
            $display("FAIL rst_pal_lo: got %h expected a3", cpu_din);
        end
        cpu_addr = 9'h145;
        tick();
        n_checks++;
        if (cpu_din !== 8'h07) begin
            n_fail++;
            $display("FAIL rst_pal_hi: got %h expected 07", cpu_din);
        end
    endtask

    initial begin
        rst      = 1'b1;
        pxl_cen  = 1'b1;
        cpu_addr = '0;
        pal_cs   = 1'b0;
        cpu_wrn  = 1'b1;
        cpu_dout = '0;
        gfx_en   = 3'b111;
        LHBL     = 1'b1;
        LVBL     = 1'b1;
        set_pxl(6'h00, 7'h00, 6'h00);
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_transparent();
        test_blank();
        test_collision();
        test_cen_hold();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtkunio_colmix.md
Name: jtkunio_colmix

Overview:
- Colour mixer for the Kunio video path; sits directly downstream of the char, scroll and object layers.
- Each pixel it picks one layer pixel by fixed priority and maps it to an 8-bit palette index.
- It looks that index up in a CPU-writable 256-entry 12-bit palette and outputs blanked 4:4:4 RGB to the video output stage.
- It also delays the blanking strobes so they stay aligned with the RGB output.

Parameters:
- BLANK_DLY, 2, pixel-enable ticks of delay applied to LHBL/LVBL; must equal the pixel pipeline latency.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pxl_cen  in  1  pixel clock enable
- cpu_addr  in  9  palette byte address; bit 8 selects the half: 0 = {G,R}, 1 = {0000,B}
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  write strobe, active low
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data
- char_pxl  in  6  char layer pixel; transparent when [2:0]==0
- scr_pxl  in  6  scroll layer pixel; always opaque
- obj_pxl  in  7  object pixel; transparent when [2:0]==0
- gfx_en  in  3  debug layer enables: [0] char, [1] scroll, [2] obj
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- red  out  4  red output
- green  out  4  green output
- blue  out  4  blue output
- LHBL_dly  out  1  LHBL delayed by BLANK_DLY ticks
- LVBL_dly  out  1  LVBL delayed by BLANK_DLY ticks

Behaviour:
- Clock, reset and enable:
  - Single clock domain; every register advances only on pxl_cen except the CPU port.
  - Synchronous active-high rst clears red/green/blue, pipeline registers, LHBL_dly and LVBL_dly to 0.
  - Palette contents are not cleared by reset.
- Stage 1 (priority select, registered on pxl_cen):
  - Char wins if gfx_en[0] and char_pxl[2:0]!=0; palette index = {2'b00, char_pxl}.
  - Else obj wins if gfx_en[2] and obj_pxl[2:0]!=0; index = {1'b1, obj_pxl}.
  - Else scroll if gfx_en[1]; index = {2'b01, scr_pxl}.
  - Else backdrop; index = 8'h00.
- Stage 2 (palette read): synchronous read of the lo and hi palette bytes at the index; data is valid on the next pxl_cen.
- Output, registered on pxl_cen:
  - red = lo[3:0], green = lo[7:4], blue = hi[3:0].
  - All three are forced to 0 when !(LHBL_dly & LVBL_dly), using the delayed strobes aligned with that same pixel.
- Latency: a pixel presented at tick N appears on RGB after tick N+2. LHBL_dly/LVBL_dly pass through a BLANK_DLY-deep shift register clocked by pxl_cen.
- CPU port:
  - Byte write when pal_cs & ~cpu_wrn, every clk regardless of pxl_cen.
  - Writes to the hi half store only bits [3:0]; hi-half reads return {4'h0, B}.
  - cpu_din is registered, one clk read latency, and shows the byte at cpu_addr.
- Collisions: a simultaneous CPU write and video read of the same entry gives the video port the old data (read-first); the new value is used from the next read onward.
- pxl_cen stuck low: outputs and the delay line hold their values; CPU writes still complete.
- Reset mid-line: pipeline flushes to black and blank; the first valid pixel reappears 2 ticks after rst falls.

Decomposition:
- Package jtkunio_colmix_pkg holds:
  - layer base indexes: CHAR_BASE 2'b00, SCR_BASE 2'b01, OBJ_BASE 1'b1;
  - BACKDROP 8'h00;
  - transparency mask width 3.
- One sub-module: jtkunio_colmix_prio, the combinational priority/index select, so it can be tested in isolation.
- Palette memory uses two existing jtframe_dual_ram instances (aw=8, dw=8); no new RAM module.

Test Plan:
- CPU writes lo[0x45]=0xA3 and hi[0x45]=0x07; then char=0, obj=0, scr=0x05 with blanking inactive -> after 2 pxl_cen, red=3, green=A, blue=7; cpu_din reads 0xA3 and 0x07.
- char=0x09 with obj=0x11 both opaque; palette[0x09]=0x21/0x0F -> char wins, RGB=(1,2,F). Set gfx_en[0]=0 -> obj index 0x91 is used.
- char=0x08 and obj=0x10 (low bits 0, so transparent), scr=0x3F -> index 0x7F is selected; disable gfx_en[1] -> backdrop 0x00 is shown.
- Pulse LHBL low for 4 ticks mid-line -> LHBL_dly falls exactly 2 ticks later and RGB=0 for exactly those 4 output ticks.
- CPU writes index 0x12 on the same clk the video reads 0x12 -> that pixel shows the old colour and the next pixel shows the new one.
- Assert rst for 1 clk mid-line with valid pixels flowing -> RGB=0, LHBL_dly=LVBL_dly=0 next cycle; palette contents are intact after release.
